// File: rtl/mem_port_arb_pkg.sv
// Shared types and helpers for the byte-serial memory port arbiter.
package mem_port_arb_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned nb);
    return (len > nb) ? nb : len;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side request/response bundle for mem_port_arbiter.
interface mem_port_arbiter_if
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = $clog2(DATA_W / BYTE_W) + 1
);
  logic [N_CH-1:0]        req_valid;
  logic [N_CH-1:0]        req_we;
  logic [N_CH*LEN_W-1:0]  req_len;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*DATA_W-1:0] req_wdata;
  logic [N_CH-1:0]        req_ready;
  logic [N_CH-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   busy;

  modport master (
    output req_valid, req_we, req_len, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_len, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy
  );
endinterface

// File: rtl/mem_port_arb_pick.sv
// Combinational one-hot request picker; search starts at channel ptr and wraps.
module mem_port_arb_pick #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt
);
  int unsigned j;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      j = 32'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (req[j] && !found) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// N_CH requesters sharing one byte-serial RAM/IO bus, one transaction in flight.
// Define MEM_PORT_ARB_RR_EN for round-robin arbitration; otherwise lowest channel wins.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = $clog2(DATA_W / BYTE_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  mem_port_arbiter_if.slave bus,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);
  localparam int unsigned NB    = DATA_W / BYTE_W;
  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [N_CH-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] mem_a_q, mem_a_d;

  logic [N_CH-1:0]   pick_gnt;
  logic              sel_we;
  logic [LEN_W-1:0]  sel_len;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [IDX_W-1:0]  nxt_ptr;

  mem_port_arb_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_len   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    nxt_ptr   = '0;
    for (int unsigned ch = 0; ch < N_CH; ch++) begin
      if (pick_gnt[ch]) begin
        sel_we    = bus.req_we[ch];
        sel_len   = bus.req_len[ch*LEN_W +: LEN_W];
        sel_addr  = bus.req_addr[ch*ADDR_W +: ADDR_W];
        sel_wdata = bus.req_wdata[ch*DATA_W +: DATA_W];
        nxt_ptr   = (ch == N_CH - 1) ? '0 : IDX_W'(ch + 1);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;
    mem_a_d        = '0;
    mem_wr         = 1'b0;
    mem_dout       = '0;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    bus.resp_rdata = '0;
    bus.busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (rdy && rst && (|bus.req_valid)) begin
          bus.req_ready = pick_gnt;
          gnt_d         = pick_gnt;
          we_d          = sel_we;
          len_d         = LEN_W'(clamp_len(32'(sel_len), NB));
          addr_d        = sel_addr;
          wdata_d       = sel_wdata;
          rdata_d       = '0;
          cnt_d         = '0;
          state_d       = (len_d == '0) ? ST_RESP : ST_XFER;
`ifdef MEM_PORT_ARB_RR_EN
          rr_ptr_d      = nxt_ptr;
`else
          rr_ptr_d      = '0;
`endif
        end
      end

      ST_XFER: begin
        if (cnt_q < len_q) mem_a_d = addr_q + ADDR_W'(cnt_q);
        if (we_q) begin
          mem_wr   = rdy;
          mem_dout = 8'(wdata_q >> {cnt_q, 3'b000});
        end
        if (rdy) begin
          if (we_q) begin
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q + LEN_W'(1) == len_q) state_d = ST_RESP;
          end else begin
            // RAM returns the byte one cycle after its address, hence the cnt-1 slot.
            if (cnt_q != '0)
              rdata_d = rdata_q | (DATA_W'(mem_din) << {cnt_q - LEN_W'(1), 3'b000});
            if (cnt_q == len_q) state_d = ST_RESP;
            else                cnt_d   = cnt_q + LEN_W'(1);
          end
        end
      end

      ST_RESP: begin
        if (rdy) begin
          bus.resp_valid = gnt_q;
          bus.resp_rdata = rdata_q;
          state_d        = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // While paused, keep presenting the last issued address so the RAM output
    // still matches the byte the capture logic expects on resume.
    if (!rdy) mem_a_d = mem_a_q;
  end

  assign mem_a = mem_a_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      mem_a_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      mem_a_q  <= mem_a_d;
    end
  end
endmodule
